// File: rtl/cpu_mul_sequencer.sv
// Multi-cycle 32x32 multiply sequencer: time-shares one pipelined 16x16 unsigned cell
// across four partial products and returns the low (MUL) or high (MULX*) result word.
module cpu_mul_sequencer #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_en,
    input  logic [31:0] mul_p,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_XSS = 2'b11;

    state_e                        state_q, state_d;
    logic [31:0]                   a_q, a_d, b_q, b_d;
    logic [1:0]                    op_q, op_d;
    logic [63:0]                   acc_q, acc_d;
    logic [1:0]                    cnt_q, cnt_d;
    logic [MUL_LATENCY-1:0]        tag_vld_q, tag_vld_d;
    logic [MUL_LATENCY-1:0][1:0]   tag_sh_q, tag_sh_d;

    logic [1:0]  issue_sh;
    logic [1:0]  n_last;
    logic [31:0] corr;
    logic [63:0] pp_shifted;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tag_vld_d = tag_vld_q;
        tag_sh_d  = tag_sh_q;

        n_last = (op_q == OP_MUL) ? 2'd2 : 2'd3;
        case (cnt_q)
            2'd0:    issue_sh = 2'd0;
            2'd3:    issue_sh = 2'd2;
            default: issue_sh = 2'd1;
        endcase

        // Signed operands are handled as unsigned products plus a high-word correction.
        corr = '0;
        if (req_op[1] && req_src1[31]) corr = corr - req_src2;
        if (req_op == OP_XSS && req_src2[31]) corr = corr - req_src1;

        case (tag_sh_q[MUL_LATENCY-1])
            2'd0:    pp_shifted = {32'b0, mul_p};
            2'd1:    pp_shifted = {16'b0, mul_p, 16'b0};
            default: pp_shifted = {mul_p, 32'b0};
        endcase

        mul_en = (state_q == ISSUE) || (state_q == DRAIN);
        if (mul_en) begin
            for (int i = MUL_LATENCY - 1; i > 0; i--) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_sh_d[i]  = tag_sh_q[i-1];
            end
            tag_vld_d[0] = (state_q == ISSUE);
            tag_sh_d[0]  = issue_sh;
        end
        if (tag_vld_q[MUL_LATENCY-1]) acc_d = acc_q + pp_shifted;

        case (state_q)
            IDLE: if (req_valid) begin
                state_d = ISSUE;
                cnt_d   = '0;
                a_d     = req_src1;
                b_d     = req_src2;
                op_d    = req_op;
                acc_d   = {corr, 32'b0};
            end
            ISSUE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == n_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(MUL_LATENCY - 1)) state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d   = IDLE;
            tag_vld_d = '0;
        end

        req_ready  = (state_q == IDLE);
        rsp_valid  = (state_q == RESP);
        rsp_result = '0;
        if (state_q == RESP) rsp_result = (op_q == OP_MUL) ? acc_q[31:0] : acc_q[63:32];
        mul_a = '0;
        mul_b = '0;
        if (state_q == ISSUE) begin
            mul_a = cnt_q[1] ? a_q[31:16] : a_q[15:0];
            mul_b = cnt_q[0] ? b_q[31:16] : b_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tag_vld_q <= '0;
            tag_sh_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tag_vld_q <= tag_vld_d;
            tag_sh_q  <= tag_sh_d;
        end
    end
endmodule
